// File: rtl/mips_uc_pkg.sv
// Shared definitions for the MIPS uC peripheral set: the register offsets
// within a timer channel's four-word window, CTRL/STATUS bit positions,
// the channel state type and the word address of the shared prescaler slot.
package mips_uc_pkg;

    // Word offsets inside one channel's window (base = 4*channel)
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // CTRL bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    // STATUS bit index
    localparam int STATUS_FLAG = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    // First word after the channel windows; holds PRESC when the prescaler
    // is built in, otherwise it is the start of the unmapped region.
    function automatic int presc_word_addr(input int channels);
        return 4 * channels;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: IDLE/RUN state, counter, reload value
// and sticky expiry flag. Register writes arrive as decoded strobes.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | EN=0, COUNT held; enabling loads COUNT from LOAD
//  ST_RUN  | EN=1, COUNT decrements per tick; at 0 sets FLAG and either
//          | reloads (AUTO=1) or drops back to IDLE (AUTO=0)
module timer_channel
    import mips_uc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ctrl_wr,
    input  logic             load_wr,
    input  logic             status_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             en,
    output logic             auto_mode,
    output logic             irq_en,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] count,
    output logic             flag
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    chan_state_e      state_q, state_d;
    logic             auto_q, auto_d;
    logic             ie_q, ie_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             flag_q, flag_d;

    // State and register file for this channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            auto_q  <= 1'b0;
            ie_q    <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            ie_q    <= ie_d;
            load_q  <= load_d;
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    // Next-state: bus writes first, then the FSM so that an expiry on the
    // same edge as a STATUS clear leaves FLAG set.
    always_comb begin
        state_d = state_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        load_d  = load_q;
        count_d = count_q;
        flag_d  = flag_q;

        if (load_wr) begin
            load_d = wdata;
        end
        if (ctrl_wr) begin
            auto_d = wdata[CTRL_AUTO];
            ie_d   = wdata[CTRL_IE];
        end
        if (status_wr && wdata[STATUS_FLAG]) begin
            flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && wdata[CTRL_EN]) begin
                    state_d = ST_RUN;
                    count_d = load_q;
                end
            end
            ST_RUN: begin
                // Disabling freezes COUNT; the pending tick is dropped.
                if (ctrl_wr && !wdata[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q != '0) begin
                        count_d = count_q - ONE;
                    end else begin
                        flag_d = 1'b1;
                        if (auto_q) begin
                            count_d = load_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign en        = (state_q == ST_RUN);
    assign auto_mode = auto_q;
    assign irq_en    = ie_q;
    assign load      = load_q;
    assign count     = count_q;
    assign flag      = flag_q;

endmodule

// File: rtl/mips_timer_bank.sv
// Multi-channel timer bank on the uC data bus. Holds address decode, the
// registered read path, the optional shared prescaler and the combined irq.
// Optional feature: define TIMER_PRESCALER_EN to add a 16-bit PRESC register
// at word address 4*CHANNELS; without it every clock is a tick and that
// address reads as zero.
module mips_timer_bank
    import mips_uc_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              wr,
    input  logic              rd,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              irq
);

    localparam int                CH_W       = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] PRESC_ADDR = ADDR_W'(presc_word_addr(CHANNELS));

    logic [CH_W-1:0]     chan_sel;
    logic [1:0]          offset;
    logic                tick;
    logic [31:0]         rd_mux;

    logic [CHANNELS-1:0] ch_en;
    logic [CHANNELS-1:0] ch_auto;
    logic [CHANNELS-1:0] ch_ie;
    logic [CHANNELS-1:0] ch_flag;
    logic [WIDTH-1:0]    ch_load  [CHANNELS];
    logic [WIDTH-1:0]    ch_count [CHANNELS];

    assign chan_sel = addr[ADDR_W-1:2];
    assign offset   = addr[1:0];

`ifdef TIMER_PRESCALER_EN
    logic [15:0] presc_q;
    logic [15:0] presc_cnt;
    logic        presc_wr;

    assign presc_wr = wr && (addr == PRESC_ADDR);
    assign tick     = (presc_cnt == presc_q);

    // Shared prescaler: a tick every PRESC+1 clocks, restarted on a PRESC write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            presc_cnt <= '0;
        end else if (presc_wr) begin
            presc_q   <= wdata[15:0];
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A channel's window matches only when the upper address bits equal its
    // index, so addresses past the last channel never reach any channel.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic hit;
        assign hit = (chan_sel == CH_W'(c));

        timer_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .ctrl_wr   (wr && hit && (offset == OFF_CTRL)),
            .load_wr   (wr && hit && (offset == OFF_LOAD)),
            .status_wr (wr && hit && (offset == OFF_STATUS)),
            .wdata     (wdata[WIDTH-1:0]),
            .en        (ch_en[c]),
            .auto_mode (ch_auto[c]),
            .irq_en    (ch_ie[c]),
            .load      (ch_load[c]),
            .count     (ch_count[c]),
            .flag      (ch_flag[c])
        );
    end

    // Read mux over current register state; unmapped addresses yield zero
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (chan_sel == CH_W'(c)) begin
                case (offset)
                    OFF_CTRL: begin
                        rd_mux[CTRL_EN]   = ch_en[c];
                        rd_mux[CTRL_AUTO] = ch_auto[c];
                        rd_mux[CTRL_IE]   = ch_ie[c];
                    end
                    OFF_LOAD:  rd_mux = 32'(ch_load[c]);
                    OFF_COUNT: rd_mux = 32'(ch_count[c]);
                    default:   rd_mux[STATUS_FLAG] = ch_flag[c];
                endcase
            end
        end
`ifdef TIMER_PRESCALER_EN
        if (addr == PRESC_ADDR) begin
            rd_mux = {16'd0, presc_q};
        end
`endif
    end

    // Registered read response and interrupt; a read in the same cycle as a
    // write sees the pre-write value because both sample the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            irq    <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) begin
                rdata <= rd_mux;
            end
            irq <= |(ch_flag & ch_ie);
        end
    end

endmodule

// File: doc/mips_timer_bank.md
# mips_timer_bank

Parametrised multi-channel down-counting timer peripheral for the MIPS microcontroller, sitting on the uC's memory-mapped data bus next to the other peripherals. Each channel supports one-shot or auto-reload operation, has its own sticky expiry flag, and contributes to one combined, level-sensitive interrupt line to the core. It generalises the fixed single-timer use in earlier uC builds to N channels of configurable counter width.

## Interface
- CHANNELS, 4, number of independent timer channels (1..8)
- WIDTH, 32, counter/load register width in bits (8..32)
- ADDR_W, 6, word-address width; must satisfy 2^ADDR_W > 4*CHANNELS
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  word address within the peripheral window
- wdata  in  32  write data
- wr  in  1  write strobe, one cycle per access
- rd  in  1  read strobe, one cycle per access
- rdata  out  32  read data, registered
- rvalid  out  1  high for one cycle when rdata is valid
- irq  out  1  OR over channels of (flag & irq_en), registered

## Operation
- Register map per channel c, base word address 4*c: +0 CTRL (bit0 EN, bit1 AUTO, bit2 IE), +1 LOAD (WIDTH bits, zero-extended on read), +2 COUNT (read-only), +3 STATUS (bit0 FLAG, write-1-to-clear).
- Unmapped addresses: writes ignored, reads return 0 with rvalid.
- Per-channel state machine: IDLE (EN=0, COUNT held) and RUN.
- IDLE->RUN: write CTRL with EN=1 while EN=0; COUNT <= LOAD in the same edge.
- Writing CTRL with EN=1 while already RUN: AUTO/IE update, COUNT not reloaded.
- RUN->IDLE: write EN=0; COUNT frozen at current value.
- In RUN, each tick: if COUNT != 0, COUNT <= COUNT-1; if COUNT == 0, FLAG <= 1 and either COUNT <= LOAD (AUTO=1, stays RUN) or EN <= 0 (AUTO=0, -> IDLE).
- Period is LOAD+1 ticks; LOAD=0 with AUTO=1 expires every tick.
- LOAD writes do not affect COUNT until the next reload.
- Simultaneous STATUS clear and expiry on the same edge: FLAG ends 1 (set wins).
- Counter arithmetic is WIDTH-bit unsigned; no underflow past 0.

## Timing
- Reset values: rdata=0, rvalid=0, irq=0; all CTRL, LOAD, COUNT, FLAG = 0; prescaler (if present) = 0.
- Writes take effect at the edge where wr=1.
- Read latency 1 cycle: rd at edge n -> rdata/rvalid valid after edge n+1; rvalid drops the following cycle unless rd is repeated. Back-to-back reads are allowed every cycle.
- wr and rd in the same cycle: the write is performed, and the read returns the pre-write value.
- irq rises one cycle after FLAG sets and falls one cycle after the last qualifying FLAG clears or IE clears.
- Reset asserted mid-count immediately clears all state; no expiry is reported.

## Configuration
- TIMER_PRESCALER_EN defined: a shared 16-bit PRESC register is placed at word address 4*CHANNELS (read/write). Ticks occur when the internal prescale counter wraps, i.e. every PRESC+1 clocks. The prescale counter restarts at 0 when PRESC is written.
- TIMER_PRESCALER_EN undefined: a tick occurs every clock, and address 4*CHANNELS is unmapped.

## Structure
- Shared package mips_uc_pkg: register offset constants (CTRL/LOAD/COUNT/STATUS), CTRL bit indices, PRESC offset helper.
- Sub-module timer_channel: one instance per channel (generate loop), containing the state machine, counter and flag. The top level holds address decode, read mux, prescaler and irq reduction.

## Test plan
- Reset: hold rst=0 mid-count, release -> all reads return 0, irq=0.
- One-shot: LOAD=5, CTRL=0b101 -> FLAG and irq set after 6 ticks; EN reads 0; COUNT reads 0.
- Auto-reload: channel 1 LOAD=3, CTRL=0b111 -> FLAG every 4 ticks; after clearing STATUS, it is set again 4 ticks later.
- Clear/expire collision: write STATUS=1 on the exact expiry edge -> FLAG reads 1, irq stays high.
- Multi-channel: ch0 LOAD=2 IE=1, ch2 LOAD=7 IE=0 -> irq only from ch0; ch2 FLAG still sets at tick 8.
- Prescaler (macro on): PRESC=9, LOAD=1, one-shot -> expiry at clock 20 after enable; PRESC read-back = 9.
